// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, requests words from a
// variable-latency instruction memory, registers the returned word for
// decode and advances sequentially or to a branch target on retirement.
// A halt or a misaligned branch target parks the stage until reset.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_halt,
  input  logic        i_branch_taken,
  input  logic [15:0] i_branch_target,
  input  logic        i_imem_rdy,
  input  logic [15:0] i_imem_data,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  output logic [15:0] o_instr,
  output logic        o_instr_valid,
  output logic [15:0] o_pc,
  output logic [15:0] o_pc_plus2,
  output logic [15:0] o_retired,
  output logic        o_halted,
  output logic        o_err
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_VALID  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_retired;
  logic        r_err;

  logic [15:0] w_pc_plus2;
  logic        w_fetch_done;
  logic        w_retire;
  logic        w_bad_target;

  assign w_pc_plus2   = r_pc + 16'd2;
  assign w_fetch_done = (r_state == S_FETCH) && i_imem_rdy;
  assign w_retire     = (r_state == S_VALID) && !i_stall;
  assign w_bad_target = i_branch_taken && i_branch_target[0];

  assign o_imem_addr = r_pc;
  assign o_pc        = r_pc;
  assign o_pc_plus2  = w_pc_plus2;
  assign o_instr     = r_instr;
  assign o_retired   = r_retired;
  assign o_err       = r_err;

  // Next-state selection and state-decoded handshake outputs.
  always_comb begin
    w_next_state  = r_state;
    o_imem_req    = 1'b0;
    o_instr_valid = 1'b0;
    o_halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_rdy) w_next_state = S_VALID;
      end
      S_VALID: begin
        o_instr_valid = 1'b1;
        if (!i_stall) begin
          if (i_halt || w_bad_target) w_next_state = S_HALTED;
          else                        w_next_state = S_FETCH;
        end
      end
      S_HALTED: begin
        o_halted = 1'b1;
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  // State register; reset abandons any outstanding memory request.
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // PC, instruction word, retirement count and sticky error.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pc      <= RESET_PC;
      r_instr   <= NOP_INSTR;
      r_retired <= 16'd0;
      r_err     <= 1'b0;
    end else begin
      if (w_fetch_done) r_instr <= i_imem_data;
      if (w_retire) begin
        r_retired <= r_retired + 16'd1;
        if (!i_halt) begin
          if (w_bad_target)        r_err <= 1'b1;
          else if (i_branch_taken) r_pc  <= i_branch_target;
          else                     r_pc  <= w_pc_plus2;
        end
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that supplies the 16-bit instruction word consumed by the decode stage. Holds the program counter and issues requests to a variable-latency instruction memory. Registers the returned word and presents it with a valid flag. Advances the PC sequentially or to a branch target when the downstream stages retire the instruction, and parks on halt or on a misaligned target.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0800, instruction word driven on `instr` after reset until the first fetch completes

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset; sampled on the clk rising edge
- stall  in  1  downstream cannot retire the current instruction this cycle
- halt  in  1  current instruction is HALT (from control)
- branch_taken  in  1  current instruction redirects the PC
- branch_target  in  16  redirect address; valid with branch_taken
- imem_rdy  in  1  instruction memory has `imem_data` valid for the outstanding request
- imem_data  in  16  instruction word from memory
- imem_req  out  1  fetch request outstanding
- imem_addr  out  16  fetch address; equals `pc`
- instr  out  16  registered instruction word to decode
- instr_valid  out  1  `instr` is a live instruction awaiting retirement
- pc  out  16  address of the current instruction
- pc_plus2  out  16  `pc + 2`, modulo 2^16, combinational
- retired  out  16  count of retired instructions, wraps
- halted  out  1  fetch stopped (halt or error)
- err  out  1  sticky misaligned-target error

## Operation
FSM states: FETCH, VALID, HALTED.

Reset takes effect when `rst` is 0 at a rising clk edge:
- state=FETCH, pc=RESET_PC, instr=NOP_INSTR, retired=0, err=0
- Reset overrides every other input, including mid-request and in HALTED.
- An outstanding memory response is discarded.

FETCH:
- imem_req=1, instr_valid=0.
- If `imem_rdy` is high on an edge: `instr`<=`imem_data`, go to VALID.
- Otherwise stay in FETCH; there is no timeout.

VALID:
- imem_req=0, instr_valid=1.
- If `stall` is high on an edge: hold all state. `instr` and `pc` are stable.
- If `stall` is low on an edge, the instruction retires:
  - retired<=retired+1 (mod 2^16)
  - If `halt`: go to HALTED, pc unchanged. Halt has priority over branch_taken.
  - Else if `branch_taken` and `branch_target[0]`=1: err<=1, go to HALTED, pc unchanged.
  - Else if `branch_taken`: pc<=branch_target, go to FETCH.
  - Else: pc<=pc+2 (16'hFFFE wraps to 16'h0000), go to FETCH.

HALTED:
- imem_req=0, instr_valid=0, halted=1.
- pc, instr, retired and err hold.
- Only reset exits HALTED.

Input qualification:
- `halt`, `branch_taken`, `branch_target` and `stall` are ignored outside VALID.
- `imem_rdy` is ignored outside FETCH.

Combinational outputs:
- `imem_addr`=`pc`.
- `pc_plus2`=`pc+2`, truncated to 16 bits.
- halted=1 exactly when state is HALTED.

## Timing
- Reset values: imem_req=1 (FETCH), instr_valid=0, instr=NOP_INSTR, pc=RESET_PC, pc_plus2=RESET_PC+2, retired=0, halted=0, err=0.
- Fetch latency: `instr_valid` rises the cycle after the edge on which `imem_rdy` is sampled high.
- Zero-wait memory (imem_rdy tied high): one instruction every 2 cycles when `stall`=0.
- A redirect takes effect on the retiring edge. The next cycle's `imem_addr` equals `branch_target`. No wrong-path fetch is issued.
- `err` and `halted` are registered and rise the cycle after the retiring edge.
- `err` is never cleared except by reset.

## Test plan
- Reset, then imem_rdy=1, words 0x1111, 0x2222, 0x3333 at 0x0000/2/4, stall=0 → instr_valid pulses every 2nd cycle, imem_addr 0x0000→0x0002→0x0004, retired=3.
- imem_rdy held low for 5 cycles in FETCH, then high with data 0xABCD → imem_req high all 6 cycles, instr=0xABCD with instr_valid the following cycle.
- In VALID at pc=0x0010, stall=1 for 3 cycles, then branch_taken=1, target=0x0100 → pc and instr stable during the stall, retired increments once, next imem_addr=0x0100.
- pc=0xFFFE, no branch, retire → pc=0x0000, pc_plus2=0x0002.
- Retire with halt=1 and branch_taken=1 → HALTED, pc unchanged, err=0, imem_req=0 indefinitely. Then rst=0 for 1 cycle → pc=RESET_PC, FETCH, retired=0.
- Retire with branch_taken=1, target=0x0203 → err=1, halted=1, pc unchanged. Err holds after 10 further cycles with arbitrary inputs.
